// File: rtl/regfile_wb_sched.sv
// regfile_wb_sched
// Write-back scheduler and pending-register scoreboard for a 32 x 64-bit
// register file. Two write-back requesters (ALU and load) share the file's
// single write port through a round-robin arbiter with valid/ready
// handshakes. The grant is registered into a write stage that drives the
// file. A pending bit per register lets issue logic stall on RAW/WAW hazards.
//
// Ports
//   clk, rst                               clock, synchronous active-high reset
//   iss_valid, iss_addr / iss_ready        issue marks a destination pending
//   a_valid, a_addr, a_data / a_ready      ALU write-back request
//   m_valid, m_addr, m_data / m_ready      load write-back request
//   rf_write_en/addr/data                  registered register-file write port
//   chk_addr1..3 / chk_busy1..3            combinational pending lookups
//   pending                                scoreboard vector
//   wb_orphan                              sticky: write-back to a non-pending register
module regfile_wb_sched #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              iss_ready,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              m_valid,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [DATA_W-1:0] m_data,
  output logic              m_ready,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] chk_addr1,
  input  logic [ADDR_W-1:0] chk_addr2,
  input  logic [ADDR_W-1:0] chk_addr3,
  output logic              chk_busy1,
  output logic              chk_busy2,
  output logic              chk_busy3,
  output logic [NREGS-1:0]  pending,
  output logic              wb_orphan
);

  // r_rr: 0 = ALU has priority on a tie, 1 = load has priority
  logic              r_rr;
  logic              r_vld_p1;
  logic [ADDR_W-1:0] r_addr_p1;
  logic [DATA_W-1:0] r_data_p1;
  logic [NREGS-1:0]  r_pending;
  logic              r_orphan;

  logic              w_a_gnt;
  logic              w_m_gnt;
  logic              w_xfer;
  logic              w_iss_fire;
  logic [NREGS-1:0]  w_set;
  logic [NREGS-1:0]  w_clr;
  logic [NREGS-1:0]  w_pending_nxt;

  // Stage p0: arbitration and issue acceptance (combinational)
  assign w_a_gnt    = !rst && a_valid && (!m_valid || !r_rr);
  assign w_m_gnt    = !rst && m_valid && (!a_valid ||  r_rr);
  assign w_xfer     = w_a_gnt || w_m_gnt;
  assign w_iss_fire = iss_valid && iss_ready;

  assign a_ready   = w_a_gnt;
  assign m_ready   = w_m_gnt;
  assign iss_ready = !rst && !r_pending[iss_addr];

  assign chk_busy1 = r_pending[chk_addr1];
  assign chk_busy2 = r_pending[chk_addr2];
  assign chk_busy3 = r_pending[chk_addr3];

  // Clear is applied first and set ORed in afterwards, so a same-edge set
  // and clear of one bit leaves it set.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_iss_fire) w_set[iss_addr] = 1'b1;
    if (r_vld_p1)   w_clr[r_addr_p1] = 1'b1;
    w_pending_nxt = (r_pending & ~w_clr) | w_set;
  end

  // Stage p1: registered write-port drive, scoreboard update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr      <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_addr_p1 <= '0;
      r_data_p1 <= '0;
      r_pending <= '0;
      r_orphan  <= 1'b0;
    end else begin
      r_vld_p1 <= w_xfer;
      if (w_xfer) begin
        r_addr_p1 <= w_a_gnt ? a_addr : m_addr;
        r_data_p1 <= w_a_gnt ? a_data : m_data;
        // Hand priority to whichever requester was not just served.
        r_rr      <= w_a_gnt;
      end
      r_pending <= w_pending_nxt;
      if (r_vld_p1 && !r_pending[r_addr_p1]) r_orphan <= 1'b1;
    end
  end

  assign rf_write_en   = r_vld_p1;
  assign rf_write_addr = r_addr_p1;
  assign rf_write_data = r_data_p1;
  assign pending       = r_pending;
  assign wb_orphan     = r_orphan;

endmodule

// File: tb/tb_regfile_wb_sched.sv
module tb_regfile_wb_sched;
  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              iss_valid;
  logic [ADDR_W-1:0] iss_addr;
  logic              iss_ready;
  logic              a_valid, m_valid, a_ready, m_ready;
  logic [ADDR_W-1:0] a_addr, m_addr;
  logic [DATA_W-1:0] a_data, m_data;
  logic              rf_write_en;
  logic [ADDR_W-1:0] rf_write_addr;
  logic [DATA_W-1:0] rf_write_data;
  logic [ADDR_W-1:0] chk_addr1, chk_addr2, chk_addr3;
  logic              chk_busy1, chk_busy2, chk_busy3;
  logic [NREGS-1:0]  pending;
  logic              wb_orphan;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
  } wb_t;
  wb_t exp_q[$];

  int total = 0;
  int bad   = 0;

  regfile_wb_sched #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_addr(iss_addr), .iss_ready(iss_ready),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data), .a_ready(a_ready),
    .m_valid(m_valid), .m_addr(m_addr), .m_data(m_data), .m_ready(m_ready),
    .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2), .chk_addr3(chk_addr3),
    .chk_busy1(chk_busy1), .chk_busy2(chk_busy2), .chk_busy3(chk_busy3),
    .pending(pending), .wb_orphan(wb_orphan)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wb_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [ADDR_W-1:0] r);
    iss_valid = 1'b1;
    iss_addr  = r;
    tick();
    iss_valid = 1'b0;
  endtask

  // Monitor: every write-port cycle must match the next expected write-back.
  always @(negedge clk) begin
    if (rf_write_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL wb_unexpected: got addr %0d data %h want no write", rf_write_addr, rf_write_data);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        chk("wb_addr", 64'(rf_write_addr), 64'(e.a));
        chk("wb_data", rf_write_data, e.d);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    iss_valid = 1'b0; iss_addr = '0;
    a_valid = 1'b1; a_addr = 5'd1; a_data = 64'h1;
    m_valid = 1'b1; m_addr = 5'd2; m_data = 64'h2;
    chk_addr1 = '0; chk_addr2 = '0; chk_addr3 = '0;

    // Reset with both requesters valid: nothing granted or written.
    repeat (2) begin
      @(negedge clk);
      chk("rst_a_ready", 64'(a_ready), 64'd0);
      chk("rst_m_ready", 64'(m_ready), 64'd0);
      chk("rst_iss_ready", 64'(iss_ready), 64'd0);
      chk("rst_wen", 64'(rf_write_en), 64'd0);
      chk("rst_pending", 64'(pending), 64'd0);
      chk("rst_orphan", 64'(wb_orphan), 64'd0);
      chk("rst_waddr", 64'(rf_write_addr), 64'd0);
      chk("rst_wdata", rf_write_data, 64'd0);
    end
    tick();
    rst = 1'b0; a_valid = 1'b0; m_valid = 1'b0;

    // First grant after reset goes to ALU.
    issue(5'd5);
    issue(5'd6);
    @(negedge clk);
    chk("iss_pending56", 64'(pending), 64'h60);
    a_valid = 1'b1; a_addr = 5'd5; a_data = 64'h55;
    m_valid = 1'b1; m_addr = 5'd6; m_data = 64'h66;
    push(5'd5, 64'h55);
    #1;
    chk("first_a_ready", 64'(a_ready), 64'd1);
    chk("first_m_ready", 64'(m_ready), 64'd0);
    tick();
    a_valid = 1'b0;
    push(5'd6, 64'h66);
    @(negedge clk);
    chk("second_m_ready", 64'(m_ready), 64'd1);
    tick();
    m_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("first_pending_clr", 64'(pending), 64'd0);

    // Issue and clear of register 7.
    tick();
    issue(5'd7);
    chk_addr1 = 5'd7; chk_addr2 = 5'd7; chk_addr3 = 5'd8;
    @(negedge clk);
    chk("p7_set", 64'(pending[7]), 64'd1);
    chk("busy1_7", 64'(chk_busy1), 64'd1);
    chk("busy2_7", 64'(chk_busy2), 64'd1);
    chk("busy3_8", 64'(chk_busy3), 64'd0);
    tick(); tick();
    a_valid = 1'b1; a_addr = 5'd7; a_data = 64'hDEAD;
    push(5'd7, 64'hDEAD);
    @(negedge clk);
    chk("a_ready_7", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    @(negedge clk);
    chk("wen_7", 64'(rf_write_en), 64'd1);
    chk("busy1_during_wb", 64'(chk_busy1), 64'd1);
    tick();
    @(negedge clk);
    chk("busy1_cleared", 64'(chk_busy1), 64'd0);
    chk("p7_clr", 64'(pending[7]), 64'd0);

    // WAW stall on register 3.
    tick();
    issue(5'd3);
    iss_valid = 1'b1; iss_addr = 5'd3;
    m_valid = 1'b1; m_addr = 5'd3; m_data = 64'h333;
    push(5'd3, 64'h333);
    @(negedge clk);
    chk("waw_stall0", 64'(iss_ready), 64'd0);
    chk("waw_m_ready", 64'(m_ready), 64'd1);
    tick();
    m_valid = 1'b0;
    @(negedge clk);
    chk("waw_stall1", 64'(iss_ready), 64'd0);
    tick();
    @(negedge clk);
    chk("waw_release", 64'(iss_ready), 64'd1);
    iss_valid = 1'b0;

    // Round-robin with both requesters continuously valid.
    tick();
    issue(5'd1); issue(5'd2); issue(5'd10); issue(5'd11);
    a_valid = 1'b1; a_addr = 5'd1;  a_data = 64'h101;
    m_valid = 1'b1; m_addr = 5'd10; m_data = 64'h110;
    push(5'd1, 64'h101); push(5'd10, 64'h110);
    push(5'd2, 64'h102); push(5'd11, 64'h111);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_a_ready", 64'(a_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_m_ready", 64'(m_ready), (k % 2 == 1) ? 64'd1 : 64'd0);
      if (k > 0) chk("rr_wen_streak", 64'(rf_write_en), 64'd1);
      tick();
      case (k)
        0: begin a_addr = 5'd2;  a_data = 64'h102; end
        1: begin m_addr = 5'd11; m_data = 64'h111; end
        2: a_valid = 1'b0;
        default: m_valid = 1'b0;
      endcase
    end

    // Lone requester granted every cycle.
    issue(5'd12); issue(5'd13); issue(5'd14);
    a_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      a_addr = 5'(12 + k);
      a_data = 64'(16'hC00 + k);
      push(5'(12 + k), 64'(16'hC00 + k));
      @(negedge clk);
      chk("lone_a_ready", 64'(a_ready), 64'd1);
      tick();
    end
    a_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    chk("rr_pending_clr", 64'(pending), 64'd0);
    chk("rr_no_orphan", 64'(wb_orphan), 64'd0);

    // Orphan write-back to non-pending register 20.
    tick();
    m_valid = 1'b1; m_addr = 5'd20; m_data = 64'h2020;
    push(5'd20, 64'h2020);
    tick();
    m_valid = 1'b0;
    @(negedge clk);
    chk("orphan_pre", 64'(wb_orphan), 64'd0);
    tick();
    @(negedge clk);
    chk("orphan_set", 64'(wb_orphan), 64'd1);
    tick(); tick();
    @(negedge clk);
    chk("orphan_held", 64'(wb_orphan), 64'd1);

    // Reset mid-flight.
    tick();
    issue(5'd9);
    a_valid = 1'b1; a_addr = 5'd9; a_data = 64'h99;
    push(5'd9, 64'h99);
    @(negedge clk);
    chk("mid_a_ready", 64'(a_ready), 64'd1);
    tick();
    a_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_wen_in_rst", 64'(rf_write_en), 64'd1);
    tick();
    rst = 1'b0;
    a_valid = 1'b1; a_addr = 5'd4; a_data = 64'h4;
    m_valid = 1'b1; m_addr = 5'd8; m_data = 64'h8;
    @(negedge clk);
    chk("mid_pending", 64'(pending), 64'd0);
    chk("mid_orphan", 64'(wb_orphan), 64'd0);
    chk("mid_wen", 64'(rf_write_en), 64'd0);
    chk("mid_rr_a", 64'(a_ready), 64'd1);
    chk("mid_rr_m", 64'(m_ready), 64'd0);
    a_valid = 1'b0; m_valid = 1'b0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
